// File: rtl/timer_pkg.sv
// Shared timer address map, reader register offsets and STATUS bit positions.
package timer_pkg;

  localparam logic [31:0] TIMER_START_ADDR         = 32'h8000_0001;
  localparam logic [31:0] TIMER_STOP_ADDR          = 32'h8000_0002;
  localparam logic [31:0] TIMER_TIMEOUT_VALUE_ADDR = 32'h8000_0003;
  localparam logic [31:0] READER_BASE_ADDR         = 32'h8000_0004;

  typedef enum logic [1:0] {
    REG_STATUS      = 2'd0,
    REG_EVENT_COUNT = 2'd1,
    REG_LAST_TS     = 2'd2,
    REG_IRQ_ENABLE  = 2'd3
  } reg_offset_e;

  localparam int unsigned STATUS_PENDING_BIT  = 0;
  localparam int unsigned STATUS_OVERFLOW_BIT = 1;

endpackage

// File: rtl/timer_event_reader_if.sv
// CPU peripheral bus as seen by the timer event reader.
interface timer_event_reader_if;
  logic [31:0] address;
  logic        rd;
  logic        wr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        rd_valid;
  logic        irq;

  modport master (output address, rd, wr, data_in, input data_out, rd_valid, irq);
  modport slave  (input address, rd, wr, data_in, output data_out, rd_valid, irq);
endinterface

// File: rtl/rise_edge_detect.sv
// Single-bit rising-edge detector; rise_c is high in the cycle din first goes high.
module rise_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise_c
);

  logic din_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) din_q <= 1'b0;
    else       din_q <= din;
  end

  assign rise_c = din & ~din_q;

endmodule

// File: rtl/timer_event_reader.sv
// Captures, timestamps and counts timer timeout events; registered CPU read port.
// Optional interrupt logic and IRQ_ENABLE register enabled by TIMER_READER_IRQ_EN.
module timer_event_reader
  import timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = READER_BASE_ADDR,
  parameter int unsigned COUNT_W   = 16,
  parameter int unsigned TS_W      = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 timeout,
  timer_event_reader_if.slave  bus
);

  logic               event_c;
  logic [31:0]        diff_c;
  logic               hit_c;
  reg_offset_e        offset_c;
  logic               clr_status_c;
  logic               clr_count_c;
  logic               count_sat_c;
  logic               irq_en_rd_c;
  logic [31:0]        rd_data_c;

  logic               pending;
  logic               overflow;
  logic [COUNT_W-1:0] event_count;
  logic [TS_W-1:0]    last_ts;
  logic [TS_W-1:0]    ts_counter;

  rise_edge_detect u_timeout_edge (
    .clk    (clk),
    .reset  (reset),
    .din    (timeout),
    .rise_c (event_c)
  );

  // Decode relative to BASE_ADDR so an unaligned base still maps four registers.
  assign diff_c       = bus.address - BASE_ADDR;
  assign hit_c        = diff_c < 32'd4;
  assign offset_c     = reg_offset_e'(diff_c[1:0]);
  assign clr_status_c = bus.rd & hit_c & (offset_c == REG_STATUS);
  assign clr_count_c  = bus.rd & hit_c & (offset_c == REG_EVENT_COUNT);
  assign count_sat_c  = &event_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ts_counter <= '0;
    else       ts_counter <= ts_counter + TS_W'(1);
  end

  // An event in the same cycle as a read-to-clear wins over the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending     <= 1'b0;
      overflow    <= 1'b0;
      event_count <= '0;
      last_ts     <= '0;
    end else begin
      if (event_c)           pending <= 1'b1;
      else if (clr_status_c) pending <= 1'b0;

      if (event_c && count_sat_c && !clr_count_c) overflow <= 1'b1;
      else if (clr_status_c)                      overflow <= 1'b0;

      if (clr_count_c)                   event_count <= event_c ? COUNT_W'(1) : '0;
      else if (event_c && !count_sat_c)  event_count <= event_count + COUNT_W'(1);

      if (event_c) last_ts <= ts_counter;
    end
  end

`ifdef TIMER_READER_IRQ_EN
  logic        irq_enable;
  logic        wr_irq_c;
  logic [30:0] unused_data_in;

  assign wr_irq_c       = bus.wr & hit_c & (offset_c == REG_IRQ_ENABLE);
  assign unused_data_in = bus.data_in[31:1];
  assign irq_en_rd_c    = irq_enable;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_enable <= 1'b0;
      bus.irq    <= 1'b0;
    end else begin
      if (wr_irq_c) irq_enable <= bus.data_in[0];
      bus.irq <= irq_enable & pending;
    end
  end
`else
  logic unused_wr_bus;

  assign unused_wr_bus = ^{bus.wr, bus.data_in};
  assign irq_en_rd_c   = 1'b0;
  assign bus.irq       = 1'b0;
`endif

  always_comb begin
    rd_data_c = '0;
    if (hit_c) begin
      case (offset_c)
        REG_STATUS: begin
          rd_data_c[STATUS_PENDING_BIT]  = pending;
          rd_data_c[STATUS_OVERFLOW_BIT] = overflow;
        end
        REG_EVENT_COUNT: rd_data_c    = 32'(event_count);
        REG_LAST_TS:     rd_data_c    = 32'(last_ts);
        REG_IRQ_ENABLE:  rd_data_c[0] = irq_en_rd_c;
        default:         rd_data_c    = '0;
      endcase
    end
  end

  // Fixed one-cycle read latency; data_out holds between reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.data_out <= '0;
      bus.rd_valid <= 1'b0;
    end else begin
      bus.rd_valid <= bus.rd;
      if (bus.rd) bus.data_out <= rd_data_c;
    end
  end

endmodule
